prbs31_bert_ctrl: RTL and testbench

Bit-error-rate test controller for the PRBS31 (x^31 + x^28 + 1) datapath. It sequences the external PRBS31 generator (seed load, run enable), acquires lock on the looped-back received bit stream with an internal self-synchronising reference LFSR, and counts checked bits and errors over a programmable window. It sits between the top-level pin wrapper and the generator: `ui_in` supplies the control and `rx_bit`, and `uo_out`/`uio_out` carry the status.

---
 rtl/prbs_pkg.sv | 21 ++
 rtl/prbs31_ref_lfsr.sv | 37 +++
 rtl/prbs31_bert_ctrl.sv | 152 +++++++++++++++
 tb/tb_prbs31_bert_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg -- shared constants for the PRBS31 (x^31 + x^28 + 1) BERT datapath.
// Holds the controller state encoding, the LFSR length, tap indices,
// generator seed and the loss-of-lock block length.
package prbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_SYNC  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int PRBS31_LEN = 31;
  localparam int TAP_A      = 27;
  localparam int TAP_B      = 30;
  localparam int BLOCK_LEN  = 32;

  localparam logic [PRBS31_LEN-1:0] PRBS31_SEED = 31'd1;

endpackage

// File: rtl/prbs31_ref_lfsr.sv
// prbs31_ref_lfsr -- 31-bit PRBS31 shift register shared by the checker
// reference and the wrapper-side generator.
// Ports:
//   clk, rst      clock, synchronous active-high reset (register clears to 0)
//   load, seed    load seed into the register (priority over shifting)
//   shift_en      advance one bit this cycle
//   rx_mode       1: shift in rx_bit (self-synchronise), 0: free-run on taps
//   rx_bit        received bit used in rx_mode
//   expected      next PRBS bit predicted from the current register
module prbs31_ref_lfsr
  import prbs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PRBS31_LEN-1:0] seed,
  input  logic                  shift_en,
  input  logic                  rx_mode,
  input  logic                  rx_bit,
  output logic                  expected
);

  logic [PRBS31_LEN-1:0] lfsr_q;

  assign expected = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= '0;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (shift_en) begin
      lfsr_q <= {lfsr_q[PRBS31_LEN-2:0], (rx_mode ? rx_bit : expected)};
    end
  end

endmodule

// File: rtl/prbs31_bert_ctrl.sv
// prbs31_bert_ctrl -- PRBS31 bit-error-rate test controller.
// Sequences the external generator (seed load, run enable), locks a
// self-synchronising reference onto rx_bit, then counts checked bits and
// mismatches over a window of win_len bits (0 = continuous).
// Optional feature macro: PRBS_ERR_INJECT_EN adds inject / tx_flip.
// Ports:
//   clk, rst_n        clock; synchronous reset, active HIGH despite the name
//   start, abort      single-cycle control pulses (abort wins)
//   win_len           window length, sampled on start
//   rx_bit, rx_valid  received bit stream
//   gen_load, gen_en  generator seed-load pulse / run enable
//   locked, done      in CHECK / window complete (level)
//   state             IDLE=0 SEED=1 SYNC=2 CHECK=3 DONE=4
//   bit_cnt, err_cnt  checked bits / mismatches (err_cnt saturates)
//   inject, tx_flip   error injection request / one-cycle transmit flip
module prbs31_bert_ctrl
  import prbs_pkg::*;
#(
  parameter int WIN_W       = 16,
  parameter int ERR_W       = 16,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             rx_bit,
  input  logic             rx_valid,
`ifdef PRBS_ERR_INJECT_EN
  input  logic             inject,
  output logic             tx_flip,
`endif
  output logic             gen_load,
  output logic             gen_en,
  output logic             locked,
  output logic             done,
  output logic [2:0]       state,
  output logic [WIN_W-1:0] bit_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_q;
  logic [4:0]       sync_cnt;
  logic [4:0]       blk_pos;
  logic [5:0]       blk_err;
  logic [5:0]       blk_err_inc;
  logic [WIN_W-1:0] bit_cnt_inc;
  logic             expected, shift_en, rx_mode;
  logic             chk_bit, mismatch, loss, win_end;

  assign state = state_q;

  prbs31_ref_lfsr u_ref (
    .clk      (clk),
    .rst      (rst_n),
    .load     (1'b0),
    .seed     (PRBS31_SEED),
    .shift_en (shift_en),
    .rx_mode  (rx_mode),
    .rx_bit   (rx_bit),
    .expected (expected)
  );

  always_comb begin
    rx_mode     = (state_q == ST_SYNC);
    shift_en    = rx_valid && !abort && (state_q == ST_SYNC || state_q == ST_CHECK);
    chk_bit     = rx_valid && !abort && (state_q == ST_CHECK);
    mismatch    = chk_bit && (rx_bit != expected);
    blk_err_inc = blk_err + {5'd0, mismatch};
    bit_cnt_inc = bit_cnt + WIN_W'(1);
    loss        = chk_bit && (blk_err_inc >= 6'(LOSS_THRESH));
    win_end     = chk_bit && (win_q != '0) && (bit_cnt_inc == win_q);

    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start) state_d = ST_SEED;
        ST_SEED:  state_d = ST_SYNC;
        ST_SYNC:  if (rx_valid && sync_cnt == 5'(PRBS31_LEN - 1)) state_d = ST_CHECK;
        // window end outranks loss of lock on the same bit
        ST_CHECK: if (win_end) state_d = ST_DONE;
                  else if (loss) state_d = ST_SYNC;
        ST_DONE:  if (start) state_d = ST_SEED;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      gen_load <= 1'b0;
      gen_en   <= 1'b0;
      locked   <= 1'b0;
      done     <= 1'b0;
      win_q    <= '0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      sync_cnt <= '0;
      blk_pos  <= '0;
      blk_err  <= '0;
    end else begin
      state_q  <= state_d;
      gen_load <= (state_d == ST_SEED);
      gen_en   <= (state_d == ST_SYNC) || (state_d == ST_CHECK);
      locked   <= (state_d == ST_CHECK);
      done     <= (state_d == ST_DONE);

      if (state_d == ST_SEED && state_q != ST_SEED) begin
        win_q    <= win_len;
        bit_cnt  <= '0;
        err_cnt  <= '0;
        sync_cnt <= '0;
        blk_pos  <= '0;
        blk_err  <= '0;
      end

      if (state_q == ST_SYNC && rx_valid && !abort)
        sync_cnt <= (state_d == ST_CHECK) ? 5'd0 : sync_cnt + 5'd1;

      if (chk_bit) begin
        bit_cnt <= bit_cnt_inc;
        if (mismatch) err_cnt <= sat_inc(err_cnt);
        if (state_d == ST_SYNC) begin
          blk_pos <= '0;
          blk_err <= '0;
        end else begin
          // blk_pos wraps naturally every 32 bits; errors restart per block
          blk_pos <= blk_pos + 5'd1;
          blk_err <= (blk_pos == 5'(BLOCK_LEN - 1)) ? 6'd0 : blk_err_inc;
        end
      end
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  // a flip lasts one cycle; an inject seen while it is high is dropped
  always_ff @(posedge clk) begin
    if (rst_n) tx_flip <= 1'b0;
    else       tx_flip <= inject && !tx_flip && !abort && (state_q == ST_CHECK);
  end
`endif

endmodule

// File: tb/tb_prbs31_bert_ctrl.sv
// tb_prbs31_bert_ctrl -- directed bench for prbs31_bert_ctrl with a
// bench-side PRBS31 generator and an expectation queue.
// Define PRBS_ERR_INJECT_EN to also exercise the injection feature.
module tb_prbs31_bert_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, rx_bit, rx_valid;
  logic [15:0] win_len;
  logic        gen_load, gen_en, locked, done;
  logic [2:0]  state;
  logic [15:0] bit_cnt, err_cnt;
`ifdef PRBS_ERR_INJECT_EN
  logic        inject, tx_flip;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [30:0] g;

  always #5 clk = ~clk;

  prbs31_bert_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .win_len  (win_len),
    .rx_bit   (rx_bit),
    .rx_valid (rx_valid),
`ifdef PRBS_ERR_INJECT_EN
    .inject   (inject),
    .tx_flip  (tx_flip),
`endif
    .gen_load (gen_load),
    .gen_en   (gen_en),
    .locked   (locked),
    .done     (done),
    .state    (state),
    .bit_cnt  (bit_cnt),
    .err_cnt  (err_cnt)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(int s, bit gl, bit ge, bit lk, bit dn);
    return {25'd0, 3'(s), gl, ge, lk, dn};
  endfunction

  function automatic logic [31:0] st();
    return {25'd0, state, gen_load, gen_en, locked, done};
  endfunction

  task automatic push(string t, logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: got %0d with no expectation queued", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) n_pass++;
    else $error("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", t, obs, obs, e, e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // one valid bit from the bench generator, optionally inverted, then idle gap
  task automatic send(bit flip, int gap);
    logic nb;
    nb       = g[27] ^ g[30];
    g        = {g[29:0], nb};
    rx_bit   = nb ^ flip;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) begin
      rx_bit = 1'($urandom);
      tick();
    end
  endtask

  task automatic run(int n, int gap);
    repeat (n) send(1'b0, gap);
  endtask

  task automatic start_test(int wl);
    win_len = 16'(wl);
    start   = 1'b1;
    push("seed_state", mk(1, 1, 0, 0, 0));
    tick();
    start = 1'b0;
    pop_chk(st());
    g = 31'd1;
    push("sync_entry", mk(2, 0, 1, 0, 0));
    tick();
    pop_chk(st());
  endtask

  task automatic sync_run(int gap);
    run(30, gap);
    push("sync_30", mk(2, 0, 1, 0, 0));
    pop_chk(st());
    push("lock_31", mk(3, 0, 1, 1, 0));
    send(1'b0, gap);
    pop_chk(st());
  endtask

  task automatic chk_final(string t, int bits, int errs);
    push({t, "_status"}, mk(4, 0, 0, 0, 1));
    push({t, "_bits"}, 32'(bits));
    push({t, "_errs"}, 32'(errs));
    pop_chk(st());
    pop_chk(32'(bit_cnt));
    pop_chk(32'(err_cnt));
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; rx_bit = 1'b0; rx_valid = 1'b0;
    win_len = 16'd0; g = 31'd1;
`ifdef PRBS_ERR_INJECT_EN
    inject = 1'b0;
`endif
    // reset values
    push("reset_status", 32'd0);
    push("reset_bits", 32'd0);
    push("reset_errs", 32'd0);
    tick(); tick();
    pop_chk(st());
    pop_chk(32'(bit_cnt));
    pop_chk(32'(err_cnt));
    rst_n = 1'b0;
    tick();

    // clean loopback, window 1000; win_len changed after start has no effect
    start_test(1000);
    win_len = 16'd5;
    sync_run(0);
    run(999, 0);
    push("clean_999_status", mk(3, 0, 1, 1, 0));
    push("clean_999_bits", 32'd999);
    pop_chk(st());
    pop_chk(32'(bit_cnt));
    send(1'b0, 0);
    chk_final("clean", 1000, 0);
    push("done_frozen_bits", 32'd1000);
    send(1'b0, 0);
    pop_chk(32'(bit_cnt));

    // single flipped bit at check bit 500
    start_test(1000);
    sync_run(0);
    run(499, 0);
    push("flip500_errs", 32'd1);
    push("flip500_locked", mk(3, 0, 1, 1, 0));
    send(1'b1, 0);
    pop_chk(32'(err_cnt));
    pop_chk(st());
    run(500, 0);
    chk_final("flip500", 1000, 1);

    // eight inverted bits in one block -> loss of lock, relock
    start_test(1000);
    sync_run(0);
    run(40, 0);
    repeat (7) send(1'b1, 0);
    push("burst7_status", mk(3, 0, 1, 1, 0));
    push("burst7_errs", 32'd7);
    pop_chk(st());
    pop_chk(32'(err_cnt));
    push("burst8_status", mk(2, 0, 1, 0, 0));
    push("burst8_errs", 32'd8);
    push("burst8_bits", 32'd48);
    send(1'b1, 0);
    pop_chk(st());
    pop_chk(32'(err_cnt));
    pop_chk(32'(bit_cnt));
    sync_run(0);
    run(951, 0);
    send(1'b0, 0);
    chk_final("burst", 1000, 8);

    // rx_valid one cycle in three
    start_test(1000);
    sync_run(2);
    send(1'b0, 0);
    push("sparse_first_bits", 32'd1);
    pop_chk(32'(bit_cnt));
    rx_bit = ~rx_bit; tick();
    rx_bit = ~rx_bit; tick();
    push("sparse_idle_bits", 32'd1);
    push("sparse_idle_errs", 32'd0);
    pop_chk(32'(bit_cnt));
    pop_chk(32'(err_cnt));
    run(999, 2);
    chk_final("sparse", 1000, 0);

    // start ignored in CHECK, abort beats start, then reset mid-CHECK
    start_test(300);
    sync_run(0);
    run(200, 0);
    start = 1'b1;
    push("start_ignored_status", mk(3, 0, 1, 1, 0));
    push("start_ignored_bits", 32'd200);
    tick();
    start = 1'b0;
    pop_chk(st());
    pop_chk(32'(bit_cnt));
    abort = 1'b1; start = 1'b1;
    push("abort_status", 32'd0);
    push("abort_bits_held", 32'd200);
    tick();
    abort = 1'b0; start = 1'b0;
    pop_chk(st());
    pop_chk(32'(bit_cnt));
    start_test(300);
    push("restart_bits_clear", 32'd0);
    pop_chk(32'(bit_cnt));
    sync_run(0);
    run(50, 0);
    rst_n = 1'b1;
    push("midreset_status", 32'd0);
    push("midreset_bits", 32'd0);
    push("midreset_errs", 32'd0);
    tick();
    rst_n = 1'b0;
    pop_chk(st());
    pop_chk(32'(bit_cnt));
    pop_chk(32'(err_cnt));

    // continuous mode keeps checking past any small count
    start_test(0);
    sync_run(0);
    run(1100, 0);
    push("cont_status", mk(3, 0, 1, 1, 0));
    push("cont_bits", 32'd1100);
    pop_chk(st());
    pop_chk(32'(bit_cnt));

`ifdef PRBS_ERR_INJECT_EN
    // injection at check bit 100, second request during the flip ignored
    abort = 1'b1; tick(); abort = 1'b0;
    start_test(300);
    sync_run(0);
    run(100, 0);
    inject = 1'b1;
    push("inject_flip_high", 32'd1);
    tick();
    pop_chk(32'(tx_flip));
    push("inject_flip_low", 32'd0);
    push("inject_errs", 32'd1);
    send(tx_flip, 0);
    inject = 1'b0;
    pop_chk(32'(tx_flip));
    pop_chk(32'(err_cnt));
    run(199, 0);
    chk_final("inject", 300, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
